i2c_target_responder: RTL
=========================

I2C_TARGET_RESPONDER -- requirements
Module: i2c_target_responder

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h50, meaning the 7-bit address this target answers to.
REQ-002 SHALL have parameter NUM_REGS, default 8, meaning the number of 8-bit internal registers (power of 2, at most 256).
REQ-003 SHALL have port clk, input, width 1: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-005 SHALL have port scl, input, width 1: bus clock from the initiator.
REQ-006 SHALL have port sda, inout, width 1: bus data, open-drain; the block drives only 1'b0 or 1'bz, never 1'b1.
REQ-007 SHALL have port busy, output, width 1: high from an address-matched START until STOP.
REQ-008 SHALL have port wr_strobe, output, width 1: one-cycle pulse when a data byte is written to a register.
REQ-009 SHALL have port wr_index, output, width 8: register index of the last write.
REQ-010 SHALL have port wr_data, output, width 8: data of the last write.

Function
REQ-011 SHALL pass scl and sda through 2-flop synchronizers plus one history flop; all edge and condition detection uses the synchronized values only.
REQ-012 SHALL detect START as sda falling while scl is high, and STOP as sda rising while scl is high; both are valid in every state and take priority over bit processing.
REQ-013 SHALL sample incoming bits on the scl rising edge, MSB first, and change its own sda drive only on the cycle after an scl falling edge is detected.
REQ-014 SHALL use states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-015 START from any state SHALL go to ADDR with the bit counter cleared; a repeated START therefore restarts the address phase.
REQ-016 STOP from any state SHALL go to IDLE, release sda, and deassert busy.
REQ-017 ADDR SHALL collect 8 bits; on a match of bits[7:1] to DEV_ADDR it goes to ADDR_ACK, otherwise to IDLE with sda released.
REQ-018 ADDR_ACK SHALL drive sda low from the falling edge after bit 8 until the next falling edge; then R/W=0 goes to PTR and R/W=1 goes to RDATA.
REQ-019 PTR SHALL load the received byte into the register pointer, then ACK in PTR_ACK and go to WDATA.
REQ-020 WDATA SHALL, after 8 bits, write register[pointer mod NUM_REGS], pulse wr_strobe for one cycle on the 8th sampling edge, update wr_index and wr_data, increment the pointer modulo 256, and ACK via WDATA_ACK; repeated bytes stay in WDATA.
REQ-021 RDATA SHALL shift out register[pointer mod NUM_REGS] MSB first, releasing sda for 1 bits and driving it low for 0 bits, then increment the pointer and go to RDATA_ACK.
REQ-022 RDATA_ACK SHALL release sda and sample the initiator's bit; ACK (0) returns to RDATA with the next byte, NACK (1) waits in IDLE-like release until STOP or START.
REQ-023 The pointer SHALL persist across transactions, so a write of only the pointer followed by a repeated-START read returns the addressed register.
REQ-024 Pointer wrap SHALL go from 8'hFF to 8'h00; register selection uses the low log2(NUM_REGS) bits.

Reset
REQ-025 During rst, the block SHALL be in IDLE with sda=z, busy=0, wr_strobe=0, wr_index=0, wr_data=0, pointer=0, all registers 0, and the synchronizers at 1.
REQ-026 Asserting rst mid-transfer SHALL release sda on the next clk and ignore bus activity until a new START after rst deasserts.

Verification
REQ-027 Write 0xA0, pointer 0x03, data 0x5A, STOP -> three ACKs; wr_strobe pulses once with wr_index=3 and wr_data=0x5A; busy falls at STOP.
REQ-028 Write to pointer 0x03, repeated START, read 0xA1, NACK -> byte 0x5A on sda, sda released after the NACK.
REQ-029 Address 0xA2 (mismatch) -> no ACK (sda stays z for the 9th clock), busy=0, no wr_strobe.
REQ-030 Burst write at pointer 0x07 with bytes 0x11 and 0x22 and NUM_REGS=8 -> reg7=0x11, reg0=0x22, pointer=0x09.
REQ-031 rst asserted during the RDATA bit 4 of a read -> sda=z on the next clk, all registers 0, and a following full write completes normally.
REQ-032 STOP injected after 3 bits of WDATA -> no wr_strobe, register unchanged, state IDLE.

Source files
------------

// File: rtl/i2c_target_responder.sv
// I2C target exposing NUM_REGS 8-bit registers behind an auto-incrementing byte pointer.
// Write: addr+W, pointer, data...; read: addr+R, then bytes from the current pointer onward.
`timescale 1ns/1ps
module i2c_target_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         NUM_REGS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic       busy,
    output logic       wr_strobe,
    output logic [7:0] wr_index,
    output logic [7:0] wr_data
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t     state_q, state_d;
    logic       scl_meta_q, scl_meta_d, scl_sync_q, scl_sync_d, scl_hist_q, scl_hist_d;
    logic       sda_meta_q, sda_meta_d, sda_sync_q, sda_sync_d, sda_hist_q, sda_hist_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       phase_q, phase_d;
    logic       nack_q, nack_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [7:0] wr_index_q, wr_index_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] regs_q [NUM_REGS];
    logic [7:0] regs_d [NUM_REGS];

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte, cur_reg;

    assign scl_rise  = scl_sync_q & ~scl_hist_q;
    assign scl_fall  = ~scl_sync_q & scl_hist_q;
    assign start_det = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
    assign stop_det  = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;
    assign rx_byte   = {shift_q[6:0], sda_sync_q};
    assign cur_reg   = regs_q[ptr_q[IDX_W-1:0]];

    always_comb begin
        scl_meta_d  = scl;
        scl_sync_d  = scl_meta_q;
        scl_hist_d  = scl_sync_q;
        sda_meta_d  = sda;
        sda_sync_d  = sda_meta_q;
        sda_hist_d  = sda_sync_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        phase_d     = phase_q;
        nack_d      = nack_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_index_d  = wr_index_q;
        wr_data_d   = wr_data_q;
        regs_d      = regs_q;

        // Bus conditions win over whatever bit the current state was handling.
        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            phase_d  = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            phase_d   = 1'b0;
                            case (state_q)
                                ADDR: begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        state_d = ADDR_ACK;
                                        rw_d    = rx_byte[0];
                                        busy_d  = 1'b1;
                                    end else begin
                                        state_d = IDLE;
                                        busy_d  = 1'b0;
                                    end
                                end
                                PTR: begin
                                    ptr_d   = rx_byte;
                                    state_d = PTR_ACK;
                                end
                                default: begin
                                    regs_d[ptr_q[IDX_W-1:0]] = rx_byte;
                                    wr_strobe_d = 1'b1;
                                    wr_index_d  = ptr_q;
                                    wr_data_d   = rx_byte;
                                    ptr_d       = ptr_q + 8'd1;
                                    state_d     = WDATA_ACK;
                                end
                            endcase
                        end
                    end
                end
                // First falling edge pulls the ACK low, the second one releases it.
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            phase_d  = 1'b0;
                            sda_oe_d = 1'b0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                state_d  = RDATA;
                                sda_oe_d = ~cur_reg[7];
                            end else if (state_q == ADDR_ACK) begin
                                state_d = PTR;
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            ptr_d     = ptr_q + 8'd1;
                            phase_d   = 1'b0;
                            state_d   = RDATA_ACK;
                        end
                    end else if (scl_fall) begin
                        sda_oe_d = ~cur_reg[3'd7 - bit_cnt_q[2:0]];
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        nack_d  = sda_sync_q;
                        phase_d = 1'b1;
                    end else if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        if (phase_q) begin
                            phase_d = 1'b0;
                            if (nack_q) begin
                                state_d = IDLE;
                            end else begin
                                state_d  = RDATA;
                                sda_oe_d = ~cur_reg[7];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_meta_q  <= 1'b1;
            scl_sync_q  <= 1'b1;
            scl_hist_q  <= 1'b1;
            sda_meta_q  <= 1'b1;
            sda_sync_q  <= 1'b1;
            sda_hist_q  <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            ptr_q       <= 8'd0;
            rw_q        <= 1'b0;
            phase_q     <= 1'b0;
            nack_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= 8'd0;
            wr_data_q   <= 8'd0;
            regs_q      <= '{default: 8'h00};
        end else begin
            scl_meta_q  <= scl_meta_d;
            scl_sync_q  <= scl_sync_d;
            scl_hist_q  <= scl_hist_d;
            sda_meta_q  <= sda_meta_d;
            sda_sync_q  <= sda_sync_d;
            sda_hist_q  <= sda_hist_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            phase_q     <= phase_d;
            nack_q      <= nack_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_index_q  <= wr_index_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
        end
    end

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_index  = wr_index_q;
    assign wr_data   = wr_data_q;

endmodule
